// File: rtl/mont_mult_seq_ctrl.sv
// Sequential Montgomery multiplier: out = a*b*2^-k mod n, one bit of a per clock.
// Optional operand checking is compiled in with `define MONT_MULT_ERR_CHECK_EN.
module mont_mult_seq_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] modulant,
  input  logic [DATA_WIDTH-1:0] bit_length,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  output logic                  err
);

  localparam int ACC_W = DATA_WIDTH + 2;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] n_q;
  logic [CNT_W-1:0]      k_q;
  logic [CNT_W-1:0]      cnt;
  logic [ACC_W-1:0]      acc;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  out_valid_q;

  logic [CNT_W-1:0]      k_clamped;
  logic [ACC_W-1:0]      sum_add;
  logic [ACC_W-1:0]      sum_red;
  logic [ACC_W-1:0]      acc_next;
  logic [ACC_W-1:0]      n_ext;
  logic [ACC_W-1:0]      final_full;
  logic                  last_iter;
  logic                  req_bad;

  // Iteration counts beyond the operand width are meaningless; clamp them.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    k_clamped = bit_length[CNT_W-1:0];
    if (bit_length > DATA_WIDTH'(DATA_WIDTH)) k_clamped = CNT_W'(DATA_WIDTH);
  end

  // Interleaved reduction step: acc < 2n keeps the sum inside ACC_W bits.
  always_comb begin
    n_ext    = {2'b00, n_q};
    sum_add  = acc + (a_q[cnt] ? {2'b00, b_q} : '0);
    sum_red  = sum_add[0] ? sum_add + n_ext : sum_add;
    acc_next = sum_red >> 1;
    final_full = (acc >= n_ext) ? acc - n_ext : acc;
    last_iter  = (cnt == k_q - CNT_W'(1));
  end

`ifdef MONT_MULT_ERR_CHECK_EN
  logic err_q;

  assign req_bad = (modulant == '0) | ~modulant[0] | (a >= modulant) | (b >= modulant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && start_valid) begin
      err_q <= req_bad;
    end else if (state == S_DONE && out_ready) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign req_bad = 1'b0;
  assign err     = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      cnt         <= '0;
      acc         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            a_q <= a;
            b_q <= b;
            n_q <= modulant;
            k_q <= k_clamped;
            cnt <= '0;
            acc <= '0;
            if (req_bad) begin
              out_q       <= '0;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end else if (k_clamped == '0) begin
              state <= S_FINAL;
            end else begin
              state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) state <= S_FINAL;
        end
        S_FINAL: begin
          // The result is below n, so truncating to DATA_WIDTH is lossless.
          out_q       <= final_full[DATA_WIDTH-1:0];
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign start_ready = (state == S_IDLE);
  assign busy        = (state == S_ITER) || (state == S_FINAL);
  assign out_valid   = out_valid_q;
  assign out         = out_q;

endmodule

// File: tb/tb_mont_mult_seq_ctrl.sv
// Directed self-checking bench for mont_mult_seq_ctrl (DATA_WIDTH = 8).
// Operand checks are exercised when MONT_MULT_ERR_CHECK_EN is defined.
module tb_mont_mult_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] a, b, modulant, bit_length;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       busy;
  logic       err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mont_mult_seq_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .modulant   (modulant),
    .bit_length (bit_length),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Handshake, scramble the inputs, then wait for out_valid.
  // lat = edges after the handshake edge at which out_valid was first seen (-1: timeout).
  task automatic run_op(input logic [7:0] n, input logic [7:0] k, input logic [7:0] av,
                        input logic [7:0] bv, output logic [7:0] res, output int lat,
                        output int busy_cyc);
    modulant = n; bit_length = k; a = av; b = bv; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; a = 8'hff; b = 8'hfe; modulant = 8'h02; bit_length = 8'h03;
    lat = -1; busy_cyc = 0; res = 8'hxx;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        lat = i; res = out;
        break;
      end
      if (busy) busy_cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; modulant = '0; bit_length = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total_cnt++; if (start_ready !== 1'b1) $display("FAIL reset_start_ready: got %b expected 1", start_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out !== 8'd0) $display("FAIL reset_out: got %0d expected 0", out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else pass_cnt++;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || start_ready !== 1'b1)
      $display("FAIL idle_out_ready: got out_valid=%b start_ready=%b expected 0/1", out_valid, start_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] res; int lat, bc;
    run_op(8'd13, 8'd4, 8'd5, 8'd7, res, lat, bc);
    total_cnt++; if (res !== 8'd3) $display("FAIL basic_out: got %0d expected 3", res); else pass_cnt++;
    total_cnt++; if (lat != 5) $display("FAIL basic_latency: got %0d expected 5", lat); else pass_cnt++;
    total_cnt++; if (bc != 5) $display("FAIL basic_busy_cycles: got %0d expected 5", bc); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL basic_err: got %b expected 0", err); else pass_cnt++;
    consume();
    total_cnt++; if (out_valid !== 1'b0 || start_ready !== 1'b1)
      $display("FAIL basic_consume: got out_valid=%b start_ready=%b expected 0/1", out_valid, start_ready);
    else pass_cnt++;
    total_cnt++; if (out !== 8'd3) $display("FAIL basic_out_kept: got %0d expected 3", out); else pass_cnt++;
  endtask

  typedef struct {
    logic [7:0] n, k, a, b, exp;
  } vec_t;

  task automatic test_vectors();
    vec_t vecs[6];
    logic [7:0] res; int lat, bc, exp_lat;
    vecs[0] = '{8'd251, 8'd8,  8'd250, 8'd250, 8'd201};
    vecs[1] = '{8'd13,  8'd4,  8'd12,  8'd12,  8'd9};
    vecs[2] = '{8'd13,  8'd4,  8'd0,   8'd7,   8'd0};
    vecs[3] = '{8'd15,  8'd4,  8'd3,   8'd5,   8'd0};   // acc == n before the final subtract
    vecs[4] = '{8'd251, 8'd20, 8'd250, 8'd250, 8'd201}; // k clamped to 8
    vecs[5] = '{8'd13,  8'd0,  8'd5,   8'd7,   8'd0};   // k == 0
    for (int i = 0; i < 6; i++) begin
      exp_lat = ((vecs[i].k > 8'd8) ? 8 : int'(vecs[i].k)) + 1;
      run_op(vecs[i].n, vecs[i].k, vecs[i].a, vecs[i].b, res, lat, bc);
      total_cnt++; if (res !== vecs[i].exp) $display("FAIL vec%0d_out: got %0d expected %0d", i, res, vecs[i].exp); else pass_cnt++;
      total_cnt++; if (lat != exp_lat) $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, exp_lat); else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] res; int lat;
    modulant = 8'd13; bit_length = 8'd4; a = 8'd5; b = 8'd7; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    a = 8'd12; b = 8'd12; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = -1; res = 8'hxx;
    for (int i = 2; i < 100; i++) begin
      if (out_valid) begin
        lat = i; res = out;
        break;
      end
      @(posedge clk); #1;
    end
    total_cnt++; if (res !== 8'd3) $display("FAIL busy_ignore_out: got %0d expected 3", res); else pass_cnt++;
    total_cnt++; if (lat != 5) $display("FAIL busy_ignore_latency: got %0d expected 5", lat); else pass_cnt++;
    consume();
  endtask

  task automatic test_back_to_back();
    logic [7:0] res; int lat, bc;
    run_op(8'd13, 8'd4, 8'd1, 8'd1, res, lat, bc);
    total_cnt++; if (res !== 8'd9) $display("FAIL b2b_first: got %0d expected 9", res); else pass_cnt++;
    consume();
    run_op(8'd13, 8'd4, 8'd5, 8'd7, res, lat, bc);
    total_cnt++; if (res !== 8'd3 || lat != 5) $display("FAIL b2b_second: got out=%0d lat=%0d expected 3/5", res, lat); else pass_cnt++;
    consume();
  endtask

  task automatic test_backpressure();
    logic [7:0] res; int lat, bc; int bad;
    run_op(8'd13, 8'd4, 8'd1, 8'd1, res, lat, bc);
    total_cnt++; if (res !== 8'd9) $display("FAIL bp_out: got %0d expected 9", res); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        modulant = 8'd13; bit_length = 8'd4; a = 8'd5; b = 8'd7; start_valid = 1'b1;
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
      if (out !== 8'd9 || out_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL bp_hold_cycle%0d: got out=%0d out_valid=%b start_ready=%b busy=%b expected 9/1/0/0",
                 i, out, out_valid, start_ready, busy);
        bad++;
      end
    end
    total_cnt++; if (bad == 0) pass_cnt++;
    consume();
    total_cnt++; if (out_valid !== 1'b0 || start_ready !== 1'b1 || out !== 8'd9)
      $display("FAIL bp_release: got out_valid=%b start_ready=%b out=%0d expected 0/1/9", out_valid, start_ready, out);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL bp_no_queue: got busy=%b out_valid=%b expected 0/0", busy, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    logic [7:0] res; int lat, bc; int seen;
    modulant = 8'd13; bit_length = 8'd4; a = 8'd5; b = 8'd7; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL midop_busy: got %b expected 1", busy); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (start_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out !== 8'd0 || err !== 1'b0)
      $display("FAIL midop_reset: got start_ready=%b busy=%b out_valid=%b out=%0d err=%b expected 1/0/0/0/0",
               start_ready, busy, out_valid, out, err);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total_cnt++; if (seen != 0) $display("FAIL midop_no_pulse: got %0d valid cycles expected 0", seen); else pass_cnt++;
    run_op(8'd13, 8'd4, 8'd5, 8'd7, res, lat, bc);
    total_cnt++; if (res !== 8'd3 || lat != 5) $display("FAIL midop_recover: got out=%0d lat=%0d expected 3/5", res, lat); else pass_cnt++;
    consume();
  endtask

`ifdef MONT_MULT_ERR_CHECK_EN
  task automatic test_err_check();
    logic [7:0] res; int lat, bc;
    run_op(8'd12, 8'd4, 8'd5, 8'd7, res, lat, bc);
    total_cnt++; if (lat != 0 || err !== 1'b1 || res !== 8'd0)
      $display("FAIL err_even_n: got lat=%0d err=%b out=%0d expected 0/1/0", lat, err, res);
    else pass_cnt++;
    consume();
    total_cnt++; if (err !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL err_clear: got err=%b out_valid=%b expected 0/0", err, out_valid);
    else pass_cnt++;
    run_op(8'd13, 8'd4, 8'd13, 8'd7, res, lat, bc);
    total_cnt++; if (lat != 0 || err !== 1'b1 || res !== 8'd0)
      $display("FAIL err_a_ge_n: got lat=%0d err=%b out=%0d expected 0/1/0", lat, err, res);
    else pass_cnt++;
    consume();
    run_op(8'd13, 8'd4, 8'd5, 8'd7, res, lat, bc);
    total_cnt++; if (lat != 5 || err !== 1'b0 || res !== 8'd3)
      $display("FAIL err_valid_req: got lat=%0d err=%b out=%0d expected 5/0/3", lat, err, res);
    else pass_cnt++;
    consume();
  endtask
`else
  task automatic test_err_check();
    logic [7:0] res; int lat, bc;
    run_op(8'd12, 8'd4, 8'd5, 8'd7, res, lat, bc);
    total_cnt++; if (err !== 1'b0 || lat != 5)
      $display("FAIL err_absent: got err=%b lat=%0d expected 0/5", err, lat);
    else pass_cnt++;
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_busy();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_err_check();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
